move_list_writer: RTL
=====================

MOVE_LIST_WRITER -- requirements
Module: move_list_writer

Interface
REQ-001 Parameter SLOTS, default 8, moves per generator FIFO word.
REQ-002 Parameter MOVE_W, default 18, payload bits per move; each slot is MOVE_W+1 bits, MSB = invalid flag.
REQ-003 Parameter ADDR_WIDTH, default 15, RAM word address width.
REQ-004 Parameter DATA_WIDTH, default 32, RAM data width; MOVE_W SHALL be at most DATA_WIDTH.
REQ-005 Parameter MAX_MOVES, default 255, move-count cap per list.
REQ-006 Ports, clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle request to write one list.
- base_addr  in  ADDR_WIDTH  list header address, sampled with start.
- src_valid  in  1  generator has a word available (its done flag).
- src_rden  out  1  read strobe; data valid on src_data the 2nd cycle after.
- src_data  in  SLOTS*(MOVE_W+1)  packed word, slot k at bits [(k+1)*(MOVE_W+1)-1 : k*(MOVE_W+1)].
- ram_wren  out  1  RAM write enable.
- ram_wraddr  out  ADDR_WIDTH  RAM write address.
- ram_wrdata  out  DATA_WIDTH  RAM write data.
- busy  out  1  list in progress.
- done  out  1  list complete; held until next accepted start.
- move_count  out  16  moves written to the current/last list.
- overflow  out  1  at least one valid move dropped by the MAX_MOVES cap.

Function
REQ-007 FSM states IDLE, FETCH, WAIT, SCAN, HEADER, TERM; all outputs registered.
REQ-008 IDLE: start=1 -> latch base_addr, clear move_count/overflow/done, set busy, go FETCH; start while busy SHALL be ignored.
REQ-009 FETCH: stay while src_valid=0; when src_valid=1 assert src_rden for exactly one cycle, go WAIT.
REQ-010 WAIT: one cycle; at its end capture src_data and load pending mask = inverted invalid flags; go SCAN.
REQ-011 SCAN: when the mask is non-zero, write the lowest set slot per cycle: ram_wrdata = zero-extended payload, ram_wraddr = base+1+move_count (mod 2^ADDR_WIDTH), then increment move_count and clear that mask bit; invalid slots cost zero cycles.
REQ-012 SCAN with an empty mask: if the captured word had every slot invalid, go HEADER; otherwise go FETCH.
REQ-013 When move_count = MAX_MOVES, further valid slots SHALL be cleared without a write and SHALL set overflow; draining continues until an all-invalid word arrives.
REQ-014 HEADER: write move_count zero-extended to base_addr; go TERM.
REQ-015 TERM: write 0 to base+1+move_count (mod 2^ADDR_WIDTH); next cycle set done=1 and busy=0, go IDLE.
REQ-016 ram_wren SHALL be high only in cycles that perform a write defined above; at most one write per cycle.
REQ-017 An all-invalid first word SHALL produce count 0: header 0 at base, terminator at base+1.

Reset
REQ-018 reset low SHALL asynchronously force IDLE, src_rden=0, ram_wren=0, ram_wraddr=0, ram_wrdata=0, busy=0, done=0, move_count=0, overflow=0, and clear the mask and data registers.
REQ-019 reset asserted mid-list SHALL abandon the list with no further RAM writes; the next start begins a fresh list.

Structure
REQ-020 Shared package chess_ctrl_pkg holds the FSM state encoding, the slot-width constant (MOVE_W+1), and the default list base (16).
REQ-021 One sub-module, slot_priority_enc: SLOTS-wide lowest-set-bit encoder that outputs index and any-set flag.

Verification
REQ-022 base=16, one word with 8 valid moves 1..8, then an all-invalid word -> writes addr 17..24 = 1..8, addr 16 = 8, addr 25 = 0; done=1, move_count=8.
REQ-023 Word with only slots 2 and 5 valid (payloads 0x2A, 0x15), then all-invalid -> addr 17 = 0x2A, 18 = 0x15, 16 = 2, 19 = 0; exactly two SCAN write cycles.
REQ-024 MAX_MOVES=4, two full valid words, then all-invalid -> 4 moves written, header 4, terminator at base+5, overflow=1.
REQ-025 ADDR_WIDTH=15, base=0x7FFE, 3 valid moves -> writes 0x7FFF, 0x0000, 0x0001; header at 0x7FFE; terminator at 0x0002.
REQ-026 src_valid held low for 10 cycles after start -> src_rden stays 0 and busy=1 throughout; then reset pulsed low mid-SCAN -> all outputs at reset values, no ram_wren until the next start.

Source files
------------

// File: rtl/chess_ctrl_pkg.sv
// Shared definitions for the chess controller move-list logic.
//   - mlw_state_e      : state encoding of the move-list writer FSM
//   - DEFAULT_MOVE_W   : default payload width of one generated move
//   - SLOT_W           : width of one slot at the default payload width (payload + invalid flag)
//   - DEFAULT_LIST_BASE: default RAM address of a move-list header
//   - slot_width()     : slot width for an arbitrary payload width
package chess_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_HEADER = 3'd4,
        ST_TERM   = 3'd5
    } mlw_state_e;

    localparam int DEFAULT_MOVE_W    = 18;
    localparam int SLOT_W            = DEFAULT_MOVE_W + 1;
    localparam int DEFAULT_LIST_BASE = 16;

    // Each slot carries the payload plus an invalid flag in its MSB.
    function automatic int slot_width(input int move_w);
        return move_w + 1;
    endfunction

endpackage

// File: rtl/slot_priority_enc.sv
// Lowest-set-bit encoder over the pending-slot mask.
// Ports:
//   req : SLOTS-wide request mask
//   idx : index of the lowest set bit (0 when nothing is set)
//   any : at least one bit of req is set
module slot_priority_enc
    import chess_ctrl_pkg::*;
#(
    parameter int SLOTS = 8,
    parameter int IDX_W = 3
) (
    input  logic [SLOTS-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic found_s;

    // Scan upward; the first set bit seen wins and later bits are ignored.
    always_comb begin
        idx     = {IDX_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            idx     = (req[i] && !found_s) ? IDX_W'(i) : idx;
            found_s = found_s | req[i];
        end
    end

    assign any = found_s;

endmodule

// File: rtl/move_list_writer.sv
// Move-list writer: pulls packed move words from the move generator FIFO and
// writes one RAM list per start request: header (move count) at the base
// address, moves at base+1.., and a zero terminator after the last move.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   start, base_addr  : list request and header address (sampled together)
//   src_valid/rden/data : generator FIFO handshake; data is captured two cycles
//                         after the read strobe is raised
//   ram_wren/wraddr/wrdata : RAM write port
//   busy, done, move_count, overflow : list status
module move_list_writer
    import chess_ctrl_pkg::*;
#(
    parameter int SLOTS      = 8,
    parameter int MOVE_W     = 18,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_MOVES  = 255
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    input  logic                                 src_valid,
    output logic                                 src_rden,
    input  logic [SLOTS*slot_width(MOVE_W)-1:0]  src_data,
    output logic                                 ram_wren,
    output logic [ADDR_WIDTH-1:0]                ram_wraddr,
    output logic [DATA_WIDTH-1:0]                ram_wrdata,
    output logic                                 busy,
    output logic                                 done,
    output logic [15:0]                          move_count,
    output logic                                 overflow
);

    localparam int SW    = slot_width(MOVE_W);
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    mlw_state_e                   state_r, state_s;
    logic [ADDR_WIDTH-1:0]        base_r, base_s;
    logic [SLOTS-1:0][MOVE_W-1:0] payload_r, payload_s;
    logic [SLOTS-1:0]             mask_r, mask_s;
    logic                         all_inv_r, all_inv_s;
    logic                         src_rden_r, src_rden_s;
    logic                         ram_wren_r, ram_wren_s;
    logic [ADDR_WIDTH-1:0]        ram_wraddr_r, ram_wraddr_s;
    logic [DATA_WIDTH-1:0]        ram_wrdata_r, ram_wrdata_s;
    logic                         busy_r, busy_s;
    logic                         done_r, done_s;
    logic [15:0]                  count_r, count_s;
    logic                         overflow_r, overflow_s;

    logic [SLOTS-1:0]             inv_flags_s;
    logic [IDX_W-1:0]             enc_idx_s;
    logic                         enc_any_s;
    logic [ADDR_WIDTH-1:0]        next_addr_s;

    // Invalid flag of every slot of the incoming word.
    always_comb begin
        inv_flags_s = {SLOTS{1'b0}};
        for (int k = 0; k < SLOTS; k++) begin
            inv_flags_s[k] = src_data[k*SW + MOVE_W];
        end
    end

    // Next move / terminator address wraps naturally at 2^ADDR_WIDTH.
    assign next_addr_s = base_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1} + ADDR_WIDTH'(count_r);

    slot_priority_enc #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W)
    ) u_enc (
        .req (mask_r),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // Next-state and next-output logic of the list-writing FSM.
    always_comb begin
        state_s      = state_r;
        base_s       = base_r;
        payload_s    = payload_r;
        mask_s       = mask_r;
        all_inv_s    = all_inv_r;
        src_rden_s   = 1'b0;
        ram_wren_s   = 1'b0;
        ram_wraddr_s = ram_wraddr_r;
        ram_wrdata_s = ram_wrdata_r;
        busy_s       = busy_r;
        done_s       = done_r;
        count_s      = count_r;
        overflow_s   = overflow_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    base_s     = base_addr;
                    count_s    = 16'd0;
                    overflow_s = 1'b0;
                    done_s     = 1'b0;
                    busy_s     = 1'b1;
                    state_s    = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (src_valid) begin
                    src_rden_s = 1'b1;
                    state_s    = ST_WAIT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                for (int k = 0; k < SLOTS; k++) begin
                    payload_s[k] = src_data[k*SW +: MOVE_W];
                end
                mask_s    = ~inv_flags_s;
                all_inv_s = &inv_flags_s;
                state_s   = ST_SCAN;
            end
            ST_SCAN: begin
                if (enc_any_s) begin
                    mask_s = mask_r & ~({{(SLOTS-1){1'b0}}, 1'b1} << enc_idx_s);
                    // Past the cap the move is dropped but still drained.
                    if (count_r < 16'(MAX_MOVES)) begin
                        ram_wren_s   = 1'b1;
                        ram_wraddr_s = next_addr_s;
                        ram_wrdata_s = DATA_WIDTH'(payload_r[enc_idx_s]);
                        count_s      = count_r + 16'd1;
                    end else begin
                        overflow_s = 1'b1;
                    end
                end else if (all_inv_r) begin
                    state_s = ST_HEADER;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HEADER: begin
                ram_wren_s   = 1'b1;
                ram_wraddr_s = base_r;
                ram_wrdata_s = DATA_WIDTH'(count_r);
                state_s      = ST_TERM;
            end
            ST_TERM: begin
                ram_wren_s   = 1'b1;
                ram_wraddr_s = next_addr_s;
                ram_wrdata_s = {DATA_WIDTH{1'b0}};
                done_s       = 1'b1;
                busy_s       = 1'b0;
                state_s      = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any list in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            base_r       <= {ADDR_WIDTH{1'b0}};
            payload_r    <= {(SLOTS*MOVE_W){1'b0}};
            mask_r       <= {SLOTS{1'b0}};
            all_inv_r    <= 1'b0;
            src_rden_r   <= 1'b0;
            ram_wren_r   <= 1'b0;
            ram_wraddr_r <= {ADDR_WIDTH{1'b0}};
            ram_wrdata_r <= {DATA_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            count_r      <= 16'd0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            base_r       <= base_s;
            payload_r    <= payload_s;
            mask_r       <= mask_s;
            all_inv_r    <= all_inv_s;
            src_rden_r   <= src_rden_s;
            ram_wren_r   <= ram_wren_s;
            ram_wraddr_r <= ram_wraddr_s;
            ram_wrdata_r <= ram_wrdata_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            count_r      <= count_s;
            overflow_r   <= overflow_s;
        end
    end

    assign src_rden   = src_rden_r;
    assign ram_wren   = ram_wren_r;
    assign ram_wraddr = ram_wraddr_r;
    assign ram_wrdata = ram_wrdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign move_count = count_r;
    assign overflow   = overflow_r;

endmodule
